// File: rtl/multi_ported_wr_sched.sv
// multi_ported_wr_sched
//   Write-port scheduler in front of the flop/LVT multi-ported memory.
//   NUM_REQ valid/ready requesters share NUM_W physical write ports through a
//   round-robin scan. Two grants to the same address are never issued in one
//   cycle, because the LVT result for that case is undefined. Granted writes
//   are registered and reach the memory one cycle after acceptance.
//
//   Optional: define MULTI_PORTED_WR_SCHED_INIT_EN to zero-fill the whole
//   array after every reset before any request is accepted.
//
// Ports
//   clk, rst   clock; asynchronous active-high reset
//   req_valid  [NUM_REQ]     per-requester write request
//   req_addr   [NUM_REQ*AW]  requester i at [i*AW +: AW]
//   req_data   [NUM_REQ*W]   requester i at [i*W +: W]
//   req_ready  [NUM_REQ]     grant; transfer completes on valid && ready
//   wen        [NUM_W]       registered memory write enables
//   waddr      [NUM_W*AW]    registered write addresses, port p at [p*AW +: AW]
//   wdata      [NUM_W*W]     registered write data, port p at [p*W +: W]
//   busy                     high while the init sweep runs

// One registered memory write port. Address/data only update on a write so
// idle ports hold their last values.
module multi_ported_wr_sched_port #(
    parameter int AW = 10,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          nwen,
    input  logic [AW-1:0] naddr,
    input  logic [W-1:0]  ndata,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [W-1:0]  wdata
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            wen <= nwen;
            if (nwen) begin
                waddr <= naddr;
                wdata <= ndata;
            end
        end
    end
endmodule

module multi_ported_wr_sched #(
    parameter int NUM_REQ = 4,
    parameter int NUM_W   = 3,
    parameter int N       = 1024,
    parameter int AW      = $clog2(N),
    parameter int W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*W-1:0]  req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_W-1:0]      wen,
    output logic [NUM_W*AW-1:0]   waddr,
    output logic [NUM_W*W-1:0]    wdata,
    output logic                  busy
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]              ptr, ptr_nxt;
    logic                       run;
    logic [NUM_REQ-1:0]         grant;
    logic [NUM_W-1:0]           nwen;
    logic [NUM_W-1:0][AW-1:0]   naddr;
    logic [NUM_W-1:0][W-1:0]    ndata;
    int                         ngnt, last, idx;
    logic                       conflict;

`ifdef MULTI_PORTED_WR_SCHED_INIT_EN
    typedef enum logic {INIT, RUN} state_t;
    localparam int CW = $clog2(N + NUM_W) + 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            cnt_nxt = cnt + CW'(NUM_W);
            // last sweep cycle: this beat covers the top of the array
            if (int'(cnt) + NUM_W >= N) state_nxt = RUN;
        end
    end

    assign run  = (state == RUN);
    assign busy = ~run;
`else
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    // Round-robin scan from ptr; the k-th grant lands on port k. A requester
    // whose address matches an earlier grant this cycle is skipped.
    always_comb begin
        grant    = '0;
        nwen     = '0;
        naddr    = '0;
        ndata    = '0;
        ngnt     = 0;
        last     = int'(ptr);
        idx      = 0;
        conflict = 1'b0;
`ifdef MULTI_PORTED_WR_SCHED_INIT_EN
        if (!run) begin
            for (int p = 0; p < NUM_W; p++) begin
                if (int'(cnt) + p < N) begin
                    nwen[p]  = 1'b1;
                    naddr[p] = AW'(int'(cnt) + p);
                end
            end
        end
`endif
        if (run) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                idx = int'(ptr) + j;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (req_valid[idx] && ngnt < NUM_W) begin
                    conflict = 1'b0;
                    for (int k = 0; k < NUM_W; k++)
                        if (k < ngnt && naddr[k] == req_addr[idx*AW +: AW]) conflict = 1'b1;
                    if (!conflict) begin
                        grant[idx] = 1'b1;
                        for (int k = 0; k < NUM_W; k++) begin
                            if (k == ngnt) begin
                                nwen[k]  = 1'b1;
                                naddr[k] = req_addr[idx*AW +: AW];
                                ndata[k] = req_data[idx*W +: W];
                            end
                        end
                        ngnt = ngnt + 1;
                        last = idx;
                    end
                end
            end
        end
        ptr_nxt = (last + 1 >= NUM_REQ) ? '0 : PW'(last + 1);
    end

    assign req_ready = grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ptr <= '0;
        else if (|grant) ptr <= ptr_nxt;
    end

    for (genvar p = 0; p < NUM_W; p++) begin : g_port
        multi_ported_wr_sched_port #(.AW(AW), .W(W)) u_port (
            .clk   (clk),
            .rst   (rst),
            .nwen  (nwen[p]),
            .naddr (naddr[p]),
            .ndata (ndata[p]),
            .wen   (wen[p]),
            .waddr (waddr[p*AW +: AW]),
            .wdata (wdata[p*W +: W])
        );
    end
endmodule

// File: tb/tb_multi_ported_wr_sched.sv
// Randomized + directed bench for multi_ported_wr_sched. A reference model
// computes grants and port writes per cycle and queues the expected registered
// port state; a monitor pops and compares one cycle later.
module tb_multi_ported_wr_sched;
    localparam int NUM_REQ = 4, NUM_W = 3, N = 1024, AW = 10, W = 32;
`ifdef MULTI_PORTED_WR_SCHED_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0, req_ready;
    logic [NUM_REQ*AW-1:0] req_addr = '0;
    logic [NUM_REQ*W-1:0]  req_data = '0;
    logic [NUM_W-1:0]      wen;
    logic [NUM_W*AW-1:0]   waddr;
    logic [NUM_W*W-1:0]    wdata;
    logic                  busy;

    always #5 clk = ~clk;

    multi_ported_wr_sched #(.NUM_REQ(NUM_REQ), .NUM_W(NUM_W), .N(N), .AW(AW), .W(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wen(wen), .waddr(waddr), .wdata(wdata), .busy(busy));

    typedef struct {
        logic [NUM_W-1:0]    wen;
        logic [NUM_W*AW-1:0] a;
        logic [NUM_W*W-1:0]  d;
    } exp_t;

    exp_t q[$];
    int npass = 0, ntot = 0;
    logic [W-1:0] dmem [N];
    logic [W-1:0] mmem [N];

    // reference model state
    int                    m_ptr, m_cnt;
    bit                    m_busy;
    logic [NUM_W*AW-1:0]   m_a;
    logic [NUM_W*W-1:0]    m_d;
    logic [NUM_REQ-1:0]    m_grant, last_ready;
    logic [NUM_REQ-1:0]    tv = '0;
    logic [NUM_REQ*AW-1:0] ta = '0;
    logic [NUM_REQ*W-1:0]  td = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_busy = INIT_EN; m_a = '0; m_d = '0; m_grant = '0;
    endtask

    // One cycle of the scheduler rules, applied to the inputs currently driven.
    task automatic model_eval();
        exp_t e;
        int   gi[$];
        int   ga[$];
        int   i, a;
        bit   dup;
        logic [NUM_REQ-1:0] er;
        er = '0;
        e.wen = '0;
        chk("busy", busy, m_busy);
        if (m_busy) begin
            for (int p = 0; p < NUM_W; p++) begin
                if (m_cnt + p < N) begin
                    e.wen[p] = 1'b1;
                    m_a[p*AW +: AW] = AW'(m_cnt + p);
                    m_d[p*W +: W] = '0;
                    mmem[m_cnt + p] = '0;
                end
            end
            if (m_cnt + NUM_W >= N) m_busy = 1'b0;
            m_cnt += NUM_W;
        end else begin
            for (int j = 0; j < NUM_REQ; j++) begin
                i = (m_ptr + j) % NUM_REQ;
                a = int'(ta[i*AW +: AW]);
                dup = 1'b0;
                foreach (ga[k]) if (ga[k] == a) dup = 1'b1;
                if (tv[i] && gi.size() < NUM_W && !dup) begin
                    gi.push_back(i);
                    ga.push_back(a);
                    er[i] = 1'b1;
                end
            end
            foreach (gi[k]) begin
                e.wen[k] = 1'b1;
                m_a[k*AW +: AW] = ta[gi[k]*AW +: AW];
                m_d[k*W +: W] = td[gi[k]*W +: W];
                mmem[ga[k]] = td[gi[k]*W +: W];
            end
            if (gi.size() > 0) m_ptr = (gi[gi.size()-1] + 1) % NUM_REQ;
        end
        chk("ready", req_ready, er);
        m_grant = er;
        e.a = m_a;
        e.d = m_d;
        q.push_back(e);
    endtask

    // Called at a negedge: drive, evaluate model, advance to the next negedge.
    task automatic step();
        req_valid = tv; req_addr = ta; req_data = td;
        #1;
        last_ready = req_ready;
        model_eval();
        @(negedge clk);
    endtask

    // Requesters that were not granted keep valid/addr/data stable.
    task automatic rand_req();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!(tv[i] && !m_grant[i])) begin
                tv[i] = 1'($urandom_range(0, 1));
                ta[i*AW +: AW] = AW'($urandom_range(0, 15));
                td[i*W +: W] = $urandom;
            end
        end
    endtask

    task automatic init_phase(input string nm);
        int cyc;
        cyc = 0;
        tv = '0;
        while (busy === 1'b1 && cyc < 400) begin
            cyc++;
            step();
            if (cyc == 1) begin
                chk({nm, "_c1_wen"}, wen, 3'b111);
                chk({nm, "_c1_addr"}, waddr, {10'd2, 10'd1, 10'd0});
            end
        end
        chk({nm, "_cycles"}, cyc, INIT_EN ? 342 : 0);
`ifdef MULTI_PORTED_WR_SCHED_INIT_EN
        chk({nm, "_last_wen"}, wen, 3'b001);
        chk({nm, "_last_addr"}, waddr[AW-1:0], 10'd1023);
`endif
    endtask

    task automatic async_reset(input string nm);
        #2 rst = 1'b1;
        #1;
        chk({nm, "_wen"}, wen, '0);
        chk({nm, "_waddr"}, waddr, '0);
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int p = 0; p < NUM_W; p++)
                    if (wen[p] === 1'b1) dmem[waddr[p*AW +: AW]] = wdata[p*W +: W];
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("port_wen", wen, e.wen);
                    chk("port_waddr", waddr, e.a);
                    chk("port_wdata", wdata, e.d);
                end
            end
        end
    end

    initial begin
        int gcnt[NUM_REQ];
        int wait_c[NUM_REQ];
        int maxwait;
        for (int i = 0; i < N; i++) begin
            dmem[i] = 32'hDEADBEEF;
            mmem[i] = 32'hDEADBEEF;
        end
        model_reset();
        @(negedge clk);
        chk("rst_wen", wen, '0);
        chk("rst_waddr", waddr, '0);
        chk("rst_wdata", wdata, '0);
        chk("rst_busy", busy, INIT_EN);
        chk("rst_ready", req_ready, '0);
        @(negedge clk);
        rst = 1'b0;

        init_phase("init");
`ifdef MULTI_PORTED_WR_SCHED_INIT_EN
        chk("zero_0", dmem[0], '0);
        chk("zero_512", dmem[512], '0);
        chk("zero_1023", dmem[1023], '0);
`endif

        // full contention from ptr=0
        tv = 4'hF; ta = {10'd40, 10'd30, 10'd20, 10'd10}; td = {32'h4, 32'h3, 32'h2, 32'h1};
        step();
        chk("cont_ready", last_ready, 4'b0111);
        chk("cont_wen", wen, 3'b111);
        chk("cont_addr", waddr, {10'd30, 10'd20, 10'd10});
        ta = {10'd40, 10'd31, 10'd21, 10'd11};
        step();
        chk("cont2_ready", last_ready, 4'b1011);
        chk("cont2_port0", waddr[AW-1:0], 10'd40);
        tv = '0;
        step();

        // idle / partial
        tv = 4'b1000; ta[3*AW +: AW] = 10'd7; td[3*W +: W] = 32'h1234;
        step();
        chk("part_ready", last_ready, 4'b1000);
        chk("part_wen", wen, 3'b001);
        chk("part_addr", waddr[AW-1:0], 10'd7);
        chk("part_data", wdata[W-1:0], 32'h1234);

        // address conflict, ptr back at 0
        tv = 4'b0101;
        ta[0 +: AW] = 10'h55; ta[2*AW +: AW] = 10'h55;
        td[0 +: W] = 32'hA; td[2*W +: W] = 32'hB;
        step();
        chk("conf_ready", last_ready, 4'b0001);
        tv = 4'b0100;
        step();
        chk("conf2_ready", last_ready, 4'b0100);
        tv = '0;
        step();
        chk("conf_mem", dmem[10'h55], 32'hB);

        // starvation: all held valid with distinct addresses
        for (int i = 0; i < NUM_REQ; i++) begin gcnt[i] = 0; wait_c[i] = 0; end
        maxwait = 0;
        tv = 4'hF;
        for (int i = 0; i < NUM_REQ; i++) ta[i*AW +: AW] = AW'(100 + i * 50);
        for (int c = 0; c < 8; c++) begin
            step();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (last_ready[i]) begin
                    if (c < 4) gcnt[i]++;
                    wait_c[i] = 0;
                    ta[i*AW +: AW] = AW'(100 + i * 50 + c + 1);
                    td[i*W +: W] = $urandom;
                end else begin
                    wait_c[i]++;
                    if (wait_c[i] > maxwait) maxwait = wait_c[i];
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) chk($sformatf("starve_cnt%0d", i), gcnt[i] >= 3, 1'b1);
        chk("starve_wait", maxwait < 4, 1'b1);

        // randomized traffic
        tv = '0;
        m_grant = '0;
        for (int c = 0; c < 300; c++) begin
            rand_req();
            step();
        end
        for (int i = 0; i < 16; i++) chk($sformatf("mem_%0d", i), dmem[i], mmem[i]);

        // reset during RUN with grants pending
        tv = 4'hF; ta = {10'd3, 10'd2, 10'd1, 10'd0};
        req_valid = tv; req_addr = ta;
        async_reset("rstrun");
        init_phase("init2");

`ifdef MULTI_PORTED_WR_SCHED_INIT_EN
        // reset during cycle 100 of the sweep
        tv = '0;
        async_reset("rstpre");
        for (int c = 0; c < 100; c++) step();
        async_reset("rstinit");
        init_phase("init3");
`endif

        m_grant = '0;
        for (int c = 0; c < 60; c++) begin
            rand_req();
            step();
        end
        tv = '0;
        step();
        step();
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
